muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit for the EX stage, covering RV32M/RV64M funct3 operations.
- Produces the EX-stage "result complete" indication that the hazard unit consumes to decide decode stalls.
- Consumes the stall and flush controls the hazard unit generates for EX.
- Runs a shift-add multiplier and a restoring divider. While an operation is in flight, the EX result is flagged incomplete.

Parameters:
- DATA_SIZE, 32, operand/result width in bits (32 or 64).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  valid M-extension instruction present in EX this cycle
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  input  DATA_SIZE  operand A (dividend / multiplicand)
- rs2_data  input  DATA_SIZE  operand B (divisor / multiplier)
- stall  input  1  stall_ex from hazard unit; freezes unit
- flush  input  1  flush_ex from hazard unit; aborts operation
- busy  output  1  operation in flight (state MUL or DIV)
- rd_complete  output  1  result valid this cycle (feeds rd_complete_ex)
- result  output  DATA_SIZE  operation result, held until next accepted start

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, rd_complete=0, result=0, all internal registers 0. A reset mid-operation discards the operation.
- Interface: clock and reset_n only; reset is asynchronous, active-low.
- States: IDLE, MUL, DIV, DONE.
- Accept: start is sampled only in IDLE or DONE with stall=0 and flush=0. start is ignored in MUL or DIV.
  - On accept, latch op and operand magnitudes (abs value for signed operands), latch the result-sign flags, and clear the counter.
  - Go to MUL for op<4, else DIV. Fast paths go directly to DONE.
- Fast paths (next state DONE, latency 1):
  - Divide by zero (rs2=0): DIV/DIVU quotient = all ones; REM/REMU remainder = rs1.
  - Signed overflow (DIV/REM with rs1 = most negative, rs2 = -1): quotient = rs1, remainder = 0.
- MUL: one shift-add step per cycle on a 2*DATA_SIZE accumulator, DATA_SIZE cycles, then DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit), DATA_SIZE cycles, then DONE.
- Counter: ceil(log2(DATA_SIZE))+1 bits. Leaves MUL/DIV when count = DATA_SIZE-1 at a clock edge; no wrap.
- DONE:
  - rd_complete=1 for exactly one cycle, unless stall holds DONE.
  - result is registered at the MUL/DIV→DONE transition, after sign correction:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half, negated product when the sign flags differ.
    - DIV: negated quotient if signs differ.
    - REM: remainder takes the dividend's sign.
  - DONE→IDLE when start=0; DONE→accept when start=1 (back-to-back allowed).
- Latency: start accepted at edge k. Iterative op → rd_complete=1 during cycle k+DATA_SIZE+1. Fast path → cycle k+1.
- busy = (state==MUL || state==DIV). rd_complete is 0 in IDLE, MUL and DIV.
- Stall: state, counter, accumulators and result frozen. rd_complete keeps its value.
- Flush: from any state → IDLE next edge, rd_complete=0. result is retained, not cleared.
- Priority: reset > flush > stall > start/iteration.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
  - Defined: MUL-class ops use a single-cycle combinational multiplier. Accept goes straight to DONE with latency 1, and the MUL state is unused. DIV path is unchanged.
  - Undefined: iterative multiplier as above, DATA_SIZE-cycle latency.

Test Plan:
- Reset: hold reset_n=0 mid-DIV → busy=0, rd_complete=0, result=0 immediately (async). After release, start DIVU 100/7 → result=14 at cycle k+33 (DATA_SIZE=32).
- Signed ops:
  - MULH 0xFFFFFFFF*0x00000002 → result=0xFFFFFFFF.
  - MULHU same operands → 0x00000001.
  - MUL → 0xFFFFFFFE.
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
- Corner cases:
  - DIVU x/0 → 0xFFFFFFFF at k+1.
  - REM 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM same operands → 0.
- Flush/stall:
  - flush at cycle 10 of a DIV → IDLE next cycle, no rd_complete pulse.
  - stall for 3 cycles during MUL → rd_complete delayed exactly 3 cycles, same result.
- Back-to-back: start held high in DONE with a new MULHSU → second result, second rd_complete pulse; start during busy ignored.
- MULDIV_FAST_MUL_EN defined: MUL 12345*678 → result=8369910 with rd_complete at k+1.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage (shift-add multiplier, restoring divider).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle combinational one.
module muldiv_unit #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DATA_SIZE-1:0] rs1_data,
  input  logic [DATA_SIZE-1:0] rs2_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 busy,
  output logic                 rd_complete,
  output logic [DATA_SIZE-1:0] result
);

  localparam int W     = DATA_SIZE;
  localparam int CNT_W = $clog2(W) + 1;

  localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0]   ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [2:0]       op_r;
  logic             neg_r;
  logic             rem_neg_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     opb_r;
  logic [2*W-1:0]   acc_r;
  logic             busy_r;
  logic             rd_complete_r;
  logic [W-1:0]     result_r;

  logic             accept_s;
  logic             a_signed_s, b_signed_s;
  logic             sign_a_s, sign_b_s;
  logic [W-1:0]     mag_a_s, mag_b_s;
  logic             div_zero_s, div_ovf_s;
  logic             fast_path_s;
  logic [W-1:0]     fast_result_s;
  logic [W:0]       mul_sum_s;
  logic [2*W-1:0]   mul_next_s;
  logic [W:0]       div_shift_s, div_diff_s;
  logic             div_ge_s;
  logic [2*W-1:0]   div_next_s;
  logic [W-1:0]     mul_final_s, div_final_s;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0]   fast_prod_s;
`endif

  function automatic logic [W-1:0] negate_w(input logic [W-1:0] v);
    negate_w = ~v + ONE_W;
  endfunction

  // Sign-correct a magnitude product, then pick the half the funct3 asks for
  function automatic logic [W-1:0] mul_result(input logic [2:0] f, input logic [2*W-1:0] p,
                                              input logic neg);
    logic [2*W-1:0] s;
    s = neg ? (~p + ONE_2W) : p;
    if (f == 3'd0) begin
      mul_result = s[W-1:0];
    end else begin
      mul_result = s[2*W-1:W];
    end
  endfunction

  // Operand decode: signedness, magnitudes and special divide cases
  always_comb begin
    accept_s   = (state_r == ST_IDLE || state_r == ST_DONE) && start && !stall && !flush;
    a_signed_s = op[2] ? !op[0] : (op != 3'd3);
    b_signed_s = op[2] ? !op[0] : !op[1];
    sign_a_s   = a_signed_s & rs1_data[W-1];
    sign_b_s   = b_signed_s & rs2_data[W-1];
    mag_a_s    = sign_a_s ? negate_w(rs1_data) : rs1_data;
    mag_b_s    = sign_b_s ? negate_w(rs2_data) : rs2_data;
    div_zero_s = (rs2_data == {W{1'b0}});
    div_ovf_s  = op[2] & !op[0] & (rs1_data == MIN_NEG) & (rs2_data == ALL_ONES);
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod_s = {{W{1'b0}}, mag_a_s} * {{W{1'b0}}, mag_b_s};
`endif

  // Single-cycle results: divide special cases and, optionally, the combinational multiplier
  always_comb begin
    fast_path_s   = 1'b0;
    fast_result_s = {W{1'b0}};
    if (op[2]) begin
      if (div_zero_s) begin
        fast_path_s   = 1'b1;
        fast_result_s = op[1] ? rs1_data : ALL_ONES;
      end else if (div_ovf_s) begin
        fast_path_s   = 1'b1;
        fast_result_s = op[1] ? {W{1'b0}} : rs1_data;
      end else begin
        fast_path_s   = 1'b0;
        fast_result_s = {W{1'b0}};
      end
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      fast_path_s   = 1'b1;
      fast_result_s = mul_result(op, fast_prod_s, sign_a_s ^ sign_b_s);
`else
      fast_path_s   = 1'b0;
      fast_result_s = {W{1'b0}};
`endif
    end
  end

  // One iteration of each datapath; acc_r holds {product} or {remainder, quotient/dividend}
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opb_r} : {(W+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[W-1:1]};
    div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    div_ge_s    = (div_shift_s >= {1'b0, opb_r});
    div_next_s  = {(div_ge_s ? div_diff_s[W-1:0] : div_shift_s[W-1:0]), acc_r[W-2:0], div_ge_s};
    mul_final_s = mul_result(op_r, mul_next_s, neg_r);
    if (op_r[1]) begin
      div_final_s = rem_neg_r ? negate_w(div_next_s[2*W-1:W]) : div_next_s[2*W-1:W];
    end else begin
      div_final_s = neg_r ? negate_w(div_next_s[W-1:0]) : div_next_s[W-1:0];
    end
  end

  // Next-state logic: flush beats stall beats accept/iteration
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else if (stall) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (fast_path_s) begin
              state_next_s = ST_DONE;
            end else if (op[2]) begin
              state_next_s = ST_DIV;
            end else begin
              state_next_s = ST_MUL;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_MUL:  state_next_s = (cnt_r == LAST_CNT) ? ST_DONE : ST_MUL;
        ST_DIV:  state_next_s = (cnt_r == LAST_CNT) ? ST_DONE : ST_DIV;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register with registered status outputs derived from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      rd_complete_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      busy_r        <= (state_next_s == ST_MUL) || (state_next_s == ST_DIV);
      rd_complete_r <= (state_next_s == ST_DONE);
    end
  end

  // Datapath: load on accept, iterate in MUL/DIV, capture the result on the way to DONE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_r      <= 3'd0;
      neg_r     <= 1'b0;
      rem_neg_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      opb_r     <= {W{1'b0}};
      acc_r     <= {(2*W){1'b0}};
      result_r  <= {W{1'b0}};
    end else if (!flush && !stall) begin
      if (accept_s) begin
        op_r      <= op;
        neg_r     <= sign_a_s ^ sign_b_s;
        rem_neg_r <= sign_a_s;
        cnt_r     <= {CNT_W{1'b0}};
        if (op[2]) begin
          opb_r <= mag_b_s;
          acc_r <= {{W{1'b0}}, mag_a_s};
        end else begin
          opb_r <= mag_a_s;
          acc_r <= {{W{1'b0}}, mag_b_s};
        end
        if (fast_path_s) begin
          result_r <= fast_result_s;
        end
      end else if (state_r == ST_MUL) begin
        acc_r <= mul_next_s;
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == LAST_CNT) begin
          result_r <= mul_final_s;
        end
      end else if (state_r == ST_DIV) begin
        acc_r <= div_next_s;
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == LAST_CNT) begin
          result_r <= div_final_s;
        end
      end
    end
  end

  assign busy        = busy_r;
  assign rd_complete = rd_complete_r;
  assign result      = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table with a result scoreboard plus
// hand-written reset, flush, stall and back-to-back sequences.
module tb_muldiv_unit;

  localparam int W      = 32;
  localparam int LAT_IT = W + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int          MUL_LAT   = 1;
  localparam int          POKE_AT   = 0;
  localparam logic [2:0]  STALL_OP  = 3'd5;
  localparam logic [31:0] STALL_EXP = 32'd18;
`else
  localparam int          MUL_LAT   = LAT_IT;
  localparam int          POKE_AT   = 3;
  localparam logic [2:0]  STALL_OP  = 3'd0;
  localparam logic [31:0] STALL_EXP = 32'd8369910;
`endif

  logic          clock, reset_n, start, stall, flush;
  logic [2:0]    op;
  logic [W-1:0]  rs1_data, rs2_data;
  logic          busy, rd_complete;
  logic [W-1:0]  result;

  muldiv_unit #(.DATA_SIZE(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .flush(flush),
    .busy(busy), .rd_complete(rd_complete), .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];
  int          n_checks = 0;
  int          n_err    = 0;

  function automatic vec_t mk(input string n, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e, input int l);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive start for one edge from the current negedge; optionally record the expected result
  task automatic issue_now(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic push, input logic [31:0] exp);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b;
    if (push) sb_q.push_back(exp);
    @(posedge clock); @(negedge clock);
    start = 1'b0;
  endtask

  // Wait for rd_complete counting cycles from accept; optional stall window and ignored start poke
  task automatic wait_done(input string name, input int exp_lat, input int stall_at,
                           input int stall_len, input int poke_at);
    int n;
    logic [31:0] e;
    n = 1;
    while (!rd_complete && n < 100) begin
      stall = (n >= stall_at) && (n < stall_at + stall_len);
      if (n == poke_at) begin
        start = 1'b1; op = 3'd5; rs2_data = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); @(negedge clock);
      n++;
    end
    stall = 1'b0;
    start = 1'b0;
    if (!rd_complete) begin
      n_checks++; n_err++;
      $display("FAIL %s/timeout: got no rd_complete after %0d cycles, required one", name, n);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      if (sb_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL %s/scoreboard: got rd_complete with no expected result queued", name);
      end else begin
        e = sb_q.pop_front();
        chk({name, "/result"}, result, e);
      end
      chk({name, "/latency"}, n, exp_lat);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(negedge clock);
    issue_now(o, a, b, 1'b1, exp);
    chk({name, "/busy"}, busy, (lat > 1) ? 1 : 0);
    wait_done(name, lat, 0, 0, 0);
    @(posedge clock); @(negedge clock);
    chk({name, "/pulse"}, rd_complete, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, e, last_exp;
    logic [63:0] p;
    logic [2:0]  o;
    int          seen;

    reset_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    op = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;

    vecs.push_back(mk("MULH_m1x2",    3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT));
    vecs.push_back(mk("MULHU_m1x2",   3'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, MUL_LAT));
    vecs.push_back(mk("MUL_m1x2",     3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MUL_LAT));
    vecs.push_back(mk("MULHSU_m1x2",  3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT));
    vecs.push_back(mk("MUL_12345",    3'd0, 32'd12345,    32'd678,      32'd8369910,  MUL_LAT));
    vecs.push_back(mk("MULH_min2",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT));
    vecs.push_back(mk("MULHU_max2",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT));
    vecs.push_back(mk("DIV_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_IT));
    vecs.push_back(mk("REM_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_IT));
    vecs.push_back(mk("DIV_7_m2",     3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT_IT));
    vecs.push_back(mk("REM_7_m2",     3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        LAT_IT));
    vecs.push_back(mk("DIVU_100_7",   3'd5, 32'd100,      32'd7,        32'd14,       LAT_IT));
    vecs.push_back(mk("REMU_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        LAT_IT));
    vecs.push_back(mk("DIVU_max_1",   3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, LAT_IT));
    vecs.push_back(mk("DIVU_by0",     3'd5, 32'd123,      32'd0,        32'hFFFFFFFF, 1));
    vecs.push_back(mk("REM_5_by0",    3'd6, 32'd5,        32'd0,        32'd5,        1));
    vecs.push_back(mk("DIV_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
    vecs.push_back(mk("REM_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1));

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset/busy", busy, 0);
    chk("reset/rd_complete", rd_complete, 0);
    chk("reset/result", result, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    last_exp = 32'd0;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (b == 32'd0) b = 32'd1;
      case (i % 3)
        0:       begin o = 3'd3; p = {32'd0, a} * {32'd0, b}; e = p[63:32]; end
        1:       begin o = 3'd5; e = a / b; end
        default: begin o = 3'd7; e = a % b; end
      endcase
      run_op("rand", o, a, b, e, (o == 3'd3) ? MUL_LAT : LAT_IT);
      last_exp = e;
    end

    // Flush ten cycles into a DIV: no pulse, result untouched
    @(negedge clock);
    issue_now(3'd4, 32'd1000, 32'd3, 1'b0, 32'd0);
    repeat (9) begin @(posedge clock); @(negedge clock); end
    flush = 1'b1;
    @(posedge clock); @(negedge clock);
    flush = 1'b0;
    chk("flush/busy", busy, 0);
    chk("flush/rd_complete", rd_complete, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clock); @(negedge clock);
      if (rd_complete) seen++;
    end
    chk("flush/no_pulse", seen, 0);
    chk("flush/result_kept", result, last_exp);

    // Three stall cycles delay completion by exactly three cycles
    @(negedge clock);
    issue_now(STALL_OP, 32'd12345, 32'd678, 1'b1, STALL_EXP);
    wait_done("stall", LAT_IT + 3, 5, 3, 0);
    @(posedge clock); @(negedge clock);
    chk("stall/pulse", rd_complete, 0);

    // Back-to-back: new start while in DONE, plus an ignored start while busy
    @(negedge clock);
    issue_now(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
    wait_done("b2b_first", LAT_IT, 0, 0, 0);
    issue_now(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000);
    wait_done("b2b_second", MUL_LAT, 0, 0, POKE_AT);
    @(posedge clock); @(negedge clock);
    chk("b2b/pulse", rd_complete, 0);

    // Asynchronous reset in the middle of a DIV
    @(negedge clock);
    issue_now(3'd4, 32'h12345678, 32'd3, 1'b0, 32'd0);
    repeat (5) begin @(posedge clock); @(negedge clock); end
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset/busy", busy, 0);
    chk("async_reset/rd_complete", rd_complete, 0);
    chk("async_reset/result", result, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_op("post_reset_DIVU", 3'd5, 32'd100, 32'd7, 32'd14, LAT_IT);

    chk("scoreboard/empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
